regfile_wr8: RTL and testbench
==============================

# regfile_wr8

Eight-entry, `width`-bit register file whose write side is the decode-and-distribute counterpart of the 8-way source select. A 3-bit destination code enables exactly one register per cycle. Two combinational read ports provide write-through bypass. A per-register busy scoreboard tracks in-flight results for the pipeline's hazard logic. The block sits between the writeback stage (write port) and decode (read ports, scoreboard issue).

## Interface
- `width`, default 16: data width of each register and of all data ports.

Ports:
- `clk` input 1: the only clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `load` input 1: write enable for the write port.
- `dest` input 3: destination register index for a write.
- `in` input width: write data.
- `src_a` input 3: read port A register index.
- `src_b` input 3: read port B register index.
- `out_a` output width: read port A data.
- `out_b` output width: read port B data.
- `issue` input 1: marks register `issue_dest` busy (result now in flight).
- `issue_dest` input 3: register index to mark busy.
- `busy_a` output 1: scoreboard bit for `src_a`, bypass-adjusted.
- `busy_b` output 1: scoreboard bit for `src_b`, bypass-adjusted.
- `busy_vec` output 8: raw registered scoreboard; bit i corresponds to register i.

## Operation
**Storage.**
- `reg[0..7]`, each `width` bits.
- `busy[7:0]`.
- Register 0 is an ordinary, writable register; it is not hardwired to zero.

**Write decode.**
- Decode `dest` to a one-hot enable, gated by `load`.
- Exactly one register is written when `load`=1. None is written when `load`=0.
- X or Z on `dest` while `load`=1 is illegal; the bench flags it with an assertion.

**Read ports.**
- Read ports are purely combinational.
- `out_a` = `in` when `load`=1 and `dest`==`src_a`; otherwise `reg[src_a]`.
- `out_b` follows the same rule using `src_b`.
- Both ports may select the same register, and either may equal `dest`.

**Scoreboard.** Next-state of `busy[i]` at the clock edge is decided in this priority order:
1. `issue`=1 and `issue_dest`==i: set to 1. This wins over a same-cycle writeback to i, because the newer producer owns the register.
2. Else `load`=1 and `dest`==i: clear to 0.
3. Else hold.

**Busy outputs.**
- `busy_a` = `busy[src_a]` AND NOT (`load`=1 and `dest`==`src_a`). The same applies to `busy_b` with `src_b`.
- The result being written this cycle is bypassed, so the read port is not stalled.
- `busy_a` and `busy_b` ignore a same-cycle `issue`; the new busy bit becomes visible the next cycle.
- `busy_vec` = the raw `busy` register, with no bypass adjustment.

**Reset.**
- `reset_n` low asynchronously clears all `reg` to 0 and all `busy` to 0.
- Consequently `out_a`, `out_b`, `busy_a`, `busy_b` and `busy_vec` are all 0 during reset, given `load`=0.
- Any write or issue in progress when reset asserts is discarded.
- After `reset_n` deasserts, the first rising edge performs normal updates.

## Timing
- Write latency: data presented with `load`=1 at edge N is readable from `reg` after edge N. It is visible on a matching read port in the same cycle through the bypass, which is zero latency.
- Issue latency: `issue` at edge N makes `busy_vec[issue_dest]` 1 after edge N.
- Clear latency: `load` at edge N makes `busy_vec[dest]` 0 after edge N, unless the same-cycle issue override applies.
- No handshake and no backpressure: every `load` and `issue` is accepted in the cycle it is presented.
- Combinational paths:
  - `src_a`/`src_b`/`dest`/`load`/`in` → `out_a`/`out_b`.
  - `src_*`/`dest`/`load` → `busy_a`/`busy_b`.
- There is no path from `issue` to any output within the same cycle.

## Test plan
1. **Reset.** Hold `reset_n`=0 mid-stream with `load`=1 and `issue`=1 → all outputs 0. Release, then read all 8 registers → all 0x0000, `busy_vec`=8'h00.
2. **Decode sweep.** For i=0..7, write 0x1111·(i+1) masked to 16 bits with `dest`=i. Read back on both ports → each register holds its own value, and no other register changes.
3. **Bypass.**
   - Stimulus: `reg[3]`=0x00AA. In the same cycle, apply `load`=1, `dest`=3, `in`=0xBEEF, `src_a`=3, `src_b`=4.
   - Required: `out_a`=0xBEEF in the same cycle, and `out_b`=`reg[4]`.
4. **Scoreboard lifecycle.**
   - Issue `issue_dest`=5 → `busy_vec`=8'h20 next cycle, and `busy_a`=1 with `src_a`=5.
   - In the writeback cycle to 5: `busy_a`=0 and `out_a`=`in`.
   - Next cycle: `busy_vec`=8'h00.
5. **Simultaneous issue and writeback.**
   - Stimulus: `busy[2]`=1. In one cycle, apply `load`=1, `dest`=2 together with `issue`=1, `issue_dest`=2.
   - Required: `reg[2]` is updated and `busy_vec[2]` stays 1.
   - Repeat with `issue_dest`=6 → `busy_vec`=8'h40.
6. **Async reset mid-cycle.** Assert `reset_n`=0 between clock edges while `busy_vec`=8'hFF and registers are nonzero → all outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_wr8.sv
// regfile_wr8: eight-entry register file with one-hot write decode, two
// combinational read ports with write-through bypass, and a per-register busy
// scoreboard used by the pipeline's hazard logic. Register 0 is an ordinary
// writable register.
module regfile_wr8 #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [2:0]       dest,
  input  logic [width-1:0] in,
  input  logic [2:0]       src_a,
  input  logic [2:0]       src_b,
  output logic [width-1:0] out_a,
  output logic [width-1:0] out_b,
  input  logic             issue,
  input  logic [2:0]       issue_dest,
  output logic             busy_a,
  output logic             busy_b,
  output logic [7:0]       busy_vec
);

  logic [width-1:0] regs [8];
  logic [7:0]       busy;
  logic [7:0]       busy_next;
  logic [7:0]       wr_en;
  logic [7:0]       iss_en;
  logic             bypass_a;
  logic             bypass_b;

  // Decode the write destination and the issue destination to one-hot enables.
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    wr_en  = 8'h00;
    iss_en = 8'h00;
    if (load)  wr_en  = 8'h01 << dest;
    if (issue) iss_en = 8'h01 << issue_dest;
  end

  // Scoreboard next state: a new issue outranks a same-cycle writeback,
  // because the newer producer now owns the register.
  always_comb begin
    busy_next = busy;
    for (int i = 0; i < 8; i++) begin
      if (iss_en[i]) begin
        busy_next[i] = 1'b1;
      end else if (wr_en[i]) begin
        busy_next[i] = 1'b0;
      end
    end
  end

  // Register storage; exactly one entry is written per enabled cycle.
  // NOTE: the array is built from flops, not a RAM macro, so it can take the
  // asynchronous clear; state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_en[i]) begin
          regs[i] <= in;
        end
      end
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 8'h00;
    end else begin
      busy <= busy_next;
    end
  end

  // A read port that matches this cycle's writeback sees the incoming data,
  // and is not reported busy since that result is being delivered now.
  always_comb begin
    bypass_a = load && (dest == src_a);
    bypass_b = load && (dest == src_b);
    out_a    = bypass_a ? in : regs[src_a];
    out_b    = bypass_b ? in : regs[src_b];
    busy_a   = busy[src_a] && !bypass_a;
    busy_b   = busy[src_b] && !bypass_b;
    busy_vec = busy;
  end

endmodule

// File: tb/tb_regfile_wr8.sv
// tb_regfile_wr8: directed scenarios plus randomized traffic for regfile_wr8,
// checked every cycle against an array/mask model of the register file.
module tb_regfile_wr8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        load = 1'b0;
  logic [2:0]  dest = 3'd0;
  logic [15:0] wdata = 16'h0000;
  logic [2:0]  src_a = 3'd0;
  logic [2:0]  src_b = 3'd0;
  logic        issue = 1'b0;
  logic [2:0]  issue_dest = 3'd0;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic        busy_a;
  logic        busy_b;
  logic [7:0]  busy_vec;

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Reference model: plain register array and busy bitmask.
  logic [15:0] m_reg [8];
  logic [7:0]  m_busy;

  regfile_wr8 #(.width(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .load(load),
    .dest(dest),
    .in(wdata),
    .src_a(src_a),
    .src_b(src_b),
    .out_a(out_a),
    .out_b(out_b),
    .issue(issue),
    .issue_dest(issue_dest),
    .busy_a(busy_a),
    .busy_b(busy_b),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update: writes land in the array; busy clears on writeback, then
  // issue sets, so a same-cycle issue wins.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_reg[i] <= 16'h0000;
      m_busy <= 8'h00;
    end else begin
      if (load) m_reg[dest] <= wdata;
      m_busy <= (m_busy & ~(load ? (8'h01 << dest) : 8'h00))
              | (issue ? (8'h01 << issue_dest) : 8'h00);
    end
  end

  // Compare process: outputs are checked mid-cycle against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("out_a", out_a, (load && dest == src_a) ? wdata : m_reg[src_a]);
      check("out_b", out_b, (load && dest == src_b) ? wdata : m_reg[src_b]);
      check("busy_a", busy_a, m_busy[src_a] && !(load && dest == src_a));
      check("busy_b", busy_b, m_busy[src_b] && !(load && dest == src_b));
      check("busy_vec", busy_vec, m_busy);
    end
  end

  // An unknown destination while writing is illegal.
  always @(negedge clk) begin
    if (reset_n && load === 1'b1) begin
      assert (!$isunknown(dest)) else $error("dest unknown while load=1");
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. Reset held mid-stream with write and issue active.
    #1;
    reset_n = 1'b0;
    load = 1'b1; dest = 3'd1; wdata = 16'hFFFF;
    issue = 1'b1; issue_dest = 3'd1;
    src_a = 3'd2; src_b = 3'd3;
    #1 cmp_en = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    check("rst_out_a", out_a, 16'h0000);
    check("rst_out_b", out_b, 16'h0000);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_busy_vec", busy_vec, 8'h00);
    next_cycle();
    load = 1'b0; issue = 1'b0;
    #1 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      src_a = 3'(i); src_b = 3'(7 - i);
      #1;
      check("rst_read_a", out_a, 16'h0000);
      check("rst_read_b", out_b, 16'h0000);
    end
    check("rst_busy_vec_after", busy_vec, 8'h00);

    // 2. Decode sweep.
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      load = 1'b1; dest = 3'(i); wdata = 16'(16'h1111 * (i + 1));
      src_a = 3'((i + 1) % 8); src_b = 3'((i + 2) % 8);
    end
    next_cycle();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      src_a = 3'(i); src_b = 3'(i);
      #1;
      check("sweep_a", out_a, 16'(16'h1111 * (i + 1)));
      check("sweep_b", out_b, 16'(16'h1111 * (i + 1)));
    end

    // 3. Bypass.
    next_cycle();
    load = 1'b1; dest = 3'd3; wdata = 16'h00AA;
    next_cycle();
    load = 1'b1; dest = 3'd3; wdata = 16'hBEEF; src_a = 3'd3; src_b = 3'd4;
    #1;
    check("bypass_a", out_a, 16'hBEEF);
    check("bypass_b", out_b, 16'h5555);
    next_cycle();
    load = 1'b0;
    #1 check("bypass_commit", out_a, 16'hBEEF);

    // 4. Scoreboard lifecycle.
    next_cycle();
    issue = 1'b1; issue_dest = 3'd5; src_a = 3'd5;
    #1 check("issue_not_visible", busy_a, 1'b0);
    next_cycle();
    issue = 1'b0;
    #1;
    check("sb_busy_vec", busy_vec, 8'h20);
    check("sb_busy_a", busy_a, 1'b1);
    next_cycle();
    load = 1'b1; dest = 3'd5; wdata = 16'h1234;
    #1;
    check("sb_wb_busy_a", busy_a, 1'b0);
    check("sb_wb_out_a", out_a, 16'h1234);
    next_cycle();
    load = 1'b0;
    #1 check("sb_cleared", busy_vec, 8'h00);

    // 5. Simultaneous issue and writeback.
    next_cycle();
    issue = 1'b1; issue_dest = 3'd2;
    next_cycle();
    load = 1'b1; dest = 3'd2; wdata = 16'hCAFE; issue = 1'b1; issue_dest = 3'd2;
    next_cycle();
    load = 1'b0; issue = 1'b0; src_a = 3'd2;
    #1;
    check("same_reg_data", out_a, 16'hCAFE);
    check("same_reg_busy", busy_vec, 8'h04);
    next_cycle();
    load = 1'b1; dest = 3'd2; wdata = 16'hD00D; issue = 1'b1; issue_dest = 3'd6;
    next_cycle();
    load = 1'b0; issue = 1'b0;
    #1;
    check("other_reg_busy", busy_vec, 8'h40);
    check("other_reg_data", out_a, 16'hD00D);

    // Randomized traffic, checked by the compare process.
    for (int n = 0; n < 2000; n++) begin
      next_cycle();
      load = 1'($urandom_range(0, 1));
      dest = 3'($urandom_range(0, 7));
      wdata = 16'($urandom);
      issue = ($urandom_range(0, 2) == 0);
      issue_dest = ($urandom_range(0, 3) == 0) ? dest : 3'($urandom_range(0, 7));
      src_a = ($urandom_range(0, 2) == 0) ? dest : 3'($urandom_range(0, 7));
      src_b = ($urandom_range(0, 3) == 0) ? src_a : 3'($urandom_range(0, 7));
    end

    // 6. Async reset mid-cycle with every register nonzero and busy.
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      load = 1'b1; dest = 3'(i); wdata = 16'(16'h0101 * (i + 1));
      issue = 1'b1; issue_dest = 3'(i);
    end
    next_cycle();
    load = 1'b0; issue = 1'b0; src_a = 3'd7; src_b = 3'd0;
    #1;
    check("pre_rst_busy_vec", busy_vec, 8'hFF);
    check("pre_rst_out_a", out_a, 16'h0808);
    #1 reset_n = 1'b0;
    #1;
    check("async_out_a", out_a, 16'h0000);
    check("async_out_b", out_b, 16'h0000);
    check("async_busy_a", busy_a, 1'b0);
    check("async_busy_b", busy_b, 1'b0);
    check("async_busy_vec", busy_vec, 8'h00);
    next_cycle();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
